food_ctrl: RTL

Food placement controller for the snake game. Samples the free-running random point generator, has the snake-body checker vet each candidate, and retries on collision. Commits a valid on-screen food position for the renderer and the eat detector. Sits between the random point generator, the body/collision checker and the game FSM, running on the VGA pixel clock.

---
 rtl/food_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/food_ctrl.sv
// -----------------------------------------------------------------------------
// food_ctrl -- food placement controller for the snake game (VGA pixel clock).
//
// On a start event (place_req, or an optional frame timeout) it samples the
// free-running random point generator, has the body checker vet the
// candidate and retries on collision. After MAX_TRIES hits the last candidate
// is committed anyway and place_fail pulses for one cycle.
//
// Optional feature macro: FOOD_TIMEOUT_EN -- when defined, uneaten food
// relocates after TIMEOUT_FRAMES frames spent idle with valid food.
//
// Ports:
//   clk_vga     in   pixel clock, the only clock
//   rst         in   asynchronous active-low reset
//   rand_x/y    in   10-bit candidate point from the random generator
//   place_req   in   one-cycle request for a new food position
//   frame_tick  in   one-cycle pulse per frame (timeout build only)
//   chk_valid   out  query to the body checker is valid
//   chk_x/y     out  queried candidate, held stable until chk_done
//   chk_done    in   checker result valid (sampled only while chk_valid=1)
//   chk_hit     in   candidate overlaps the snake, qualified by chk_done
//   food_x/y    out  committed food position
//   food_valid  out  food may be drawn or eaten
//   place_busy  out  placement in progress
//   place_fail  out  one-cycle pulse: tries exhausted, last candidate used
// -----------------------------------------------------------------------------
module food_ctrl #(
    parameter int MAX_TRIES      = 8,    // 1..15
    parameter int TIMEOUT_FRAMES = 600   // 1..1023
) (
    input  logic       clk_vga,
    input  logic       rst,
    input  logic [9:0] rand_x,
    input  logic [9:0] rand_y,
    input  logic       place_req,
    input  logic       frame_tick,
    output logic       chk_valid,
    output logic [9:0] chk_x,
    output logic [9:0] chk_y,
    input  logic       chk_done,
    input  logic       chk_hit,
    output logic [9:0] food_x,
    output logic [9:0] food_y,
    output logic       food_valid,
    output logic       place_busy,
    output logic       place_fail
);

    typedef enum logic [1:0] {IDLE, SAMPLE, CHECK, COMMIT} state_e;

    state_e     state_q, state_d;
    logic [3:0] try_cnt_q, try_cnt_d;
    logic       fail_q, fail_d;
    logic       chk_valid_q, chk_valid_d;
    // The chk_x/chk_y registers double as the candidate register: the
    // candidate must be presented unchanged for the whole query anyway.
    logic [9:0] chk_x_q, chk_x_d;
    logic [9:0] chk_y_q, chk_y_d;
    logic [9:0] food_x_q, food_x_d;
    logic [9:0] food_y_q, food_y_d;
    logic       food_valid_q, food_valid_d;
    logic       busy_q, busy_d;
    logic       place_fail_q, place_fail_d;

    logic       timeout;
    logic       start;

    // place_req and timeout together still form a single start event.
    assign start = (state_q == IDLE) && (place_req || timeout);

`ifdef FOOD_TIMEOUT_EN
    logic [9:0] frame_cnt_q, frame_cnt_d;
    logic       frame_inc;

    assign frame_inc = (state_q == IDLE) && food_valid_q && frame_tick;
    // Fire on the tick that brings the count to TIMEOUT_FRAMES, so the
    // relocation starts on exactly the TIMEOUT_FRAMES-th frame.
    assign timeout   = frame_inc && (frame_cnt_q == 10'(TIMEOUT_FRAMES - 1));

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (start) begin
            frame_cnt_d = '0;
        end else if (frame_inc) begin
            frame_cnt_d = frame_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    logic unused_frame_tick;
    assign unused_frame_tick = frame_tick;
    assign timeout           = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        try_cnt_d    = try_cnt_q;
        fail_d       = fail_q;
        chk_valid_d  = chk_valid_q;
        chk_x_d      = chk_x_q;
        chk_y_d      = chk_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        busy_d       = busy_q;
        place_fail_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SAMPLE;
                    food_valid_d = 1'b0;
                    busy_d       = 1'b1;
                    try_cnt_d    = '0;
                    fail_d       = 1'b0;
                end
            end
            SAMPLE: begin
                chk_x_d     = rand_x;
                chk_y_d     = rand_y;
                try_cnt_d   = try_cnt_q + 4'd1;
                chk_valid_d = 1'b1;
                state_d     = CHECK;
            end
            CHECK: begin
                // chk_valid is always high in CHECK, so chk_done is qualified.
                if (chk_done) begin
                    chk_valid_d = 1'b0;
                    if (!chk_hit) begin
                        state_d = COMMIT;
                    end else if (try_cnt_q < 4'(MAX_TRIES)) begin
                        state_d = SAMPLE;
                    end else begin
                        state_d = COMMIT;
                        fail_d  = 1'b1;
                    end
                end
            end
            COMMIT: begin
                food_x_d     = chk_x_q;
                food_y_d     = chk_y_q;
                food_valid_d = 1'b1;
                busy_d       = 1'b0;
                place_fail_d = fail_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the clock edge.
    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            try_cnt_q    <= '0;
            fail_q       <= 1'b0;
            chk_valid_q  <= 1'b0;
            chk_x_q      <= '0;
            chk_y_q      <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            place_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            try_cnt_q    <= try_cnt_d;
            fail_q       <= fail_d;
            chk_valid_q  <= chk_valid_d;
            chk_x_q      <= chk_x_d;
            chk_y_q      <= chk_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            busy_q       <= busy_d;
            place_fail_q <= place_fail_d;
        end
    end

    assign chk_valid  = chk_valid_q;
    assign chk_x      = chk_x_q;
    assign chk_y      = chk_y_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign place_busy = busy_q;
    assign place_fail = place_fail_q;

endmodule
